alu_sequencer: RTL and testbench

- Command-driven controller for the 8-bit accumulator ALU.
- Accepts one opcode/operand command at a time over a valid/ready handshake and drives the ALU operand, input-mux and output-mux selects.
- Waits the ALU result latency, then commits the result to the accumulator and returns it with an overflow error flag over a second valid/ready handshake.
- Sits between the host/command source and the ALU datapath. Replaces the ad-hoc off/ready/run/error FSM.

---
 rtl/alu_sequencer_if.sv | 37 +++
 rtl/alu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Command / response handshake bundle between a host and the
//                ALU sequencer.
//                Ports (slave view = sequencer side):
//                  cmd_valid/cmd_ready/cmd_op/cmd_data : command channel
//                  rsp_valid/rsp_ready/rsp_data/rsp_error : response channel
//                  err_clear : host request to leave the error state
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic             err_clear;

    // Host side
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, err_clear,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, err_clear,
        output cmd_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Command-driven controller for the 8-bit accumulator ALU.
//                Accepts one command at a time, drives ALU operand and mux
//                selects, waits the ALU latency, commits the result to the
//                accumulator and returns it with an overflow flag.
//  Ports       : clk          rising-edge clock
//                rst          asynchronous active-high reset
//                bus          command/response handshake (slave modport)
//                alu_num2     ALU second operand
//                alu_in_sel   one-hot {clear, load_operand, writeback}
//                alu_out_sel  one-hot {mult, sub, add, not, xor, or, and}
//                alu_result   ALU output
//                alu_overflow ALU overflow flag
//                state        current state encoding
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_sequencer_if.slave        bus,
    output logic [WIDTH-1:0]      alu_num2,
    output logic [2:0]            alu_in_sel,
    output logic [6:0]            alu_out_sel,
    input  wire logic [WIDTH-1:0] alu_result,
    input  wire logic             alu_overflow,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [2:0] c_OP_XOR  = 3'd3;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_ADD  = 3'd4;
    localparam logic [2:0] c_OP_SUB  = 3'd5;
    localparam logic [2:0] c_OP_MULT = 3'd6;
    localparam logic [2:0] c_OP_LOAD = 3'd7;
    localparam logic [3:0] c_LAT_LAST = 4'(ALU_LAT - 1);

    localparam logic [2:0] c_IN_HOLD  = 3'b000;
    localparam logic [2:0] c_IN_WB    = 3'b001;
    localparam logic [2:0] c_IN_LOAD  = 3'b010;
    localparam logic [2:0] c_IN_CLEAR = 3'b100;

    state_t           r_state;
    state_t           w_nextState;
    logic [2:0]       w_inSel;
    logic [6:0]       w_opSel;
    logic             w_accept;
    logic             w_isArith;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_count;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspData;
    logic             r_rspError;
    logic [WIDTH-1:0] r_num2;
    logic [6:0]       r_outSel;
    logic             r_firstResp;   // high only in the first RESP cycle

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_isArith = (r_op == c_OP_ADD) || (r_op == c_OP_SUB) || (r_op == c_OP_MULT);

    // Output-mux select follows the ALU's unit order {mult,sub,add,not,xor,
    // or,and}, where NOT and XOR sit in the opposite order to their opcodes.
    always_comb begin
        w_opSel = 7'd1 << bus.cmd_op;
        case (bus.cmd_op)
            c_OP_NOT: w_opSel = 7'b0001000;
            c_OP_XOR: w_opSel = 7'b0000100;
            default:  w_opSel = 7'd1 << bus.cmd_op;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // --------------------------------------------- next state / input select
    always_comb begin
        w_nextState = r_state;
        w_inSel     = c_IN_HOLD;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) w_nextState = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_op == c_OP_LOAD) begin
                    w_inSel     = c_IN_LOAD;
                    w_nextState = S_RESP;
                end else begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == c_LAT_LAST) w_nextState = S_RESP;
            end
            S_RESP: begin
                // LOAD already landed in ISSUE; an overflowed result is dropped.
                if (r_firstResp && (r_op != c_OP_LOAD) && !r_rspError) begin
                    w_inSel = c_IN_WB;
                end
                if (bus.rsp_ready) begin
                    w_nextState = r_rspError ? S_ERROR : S_IDLE;
                end
            end
            S_ERROR: begin
                if (bus.err_clear) begin
                    w_inSel     = c_IN_CLEAR;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 3'd0;
            r_data      <= '0;
            r_count     <= 4'd0;
            r_rspValid  <= 1'b0;
            r_rspData   <= '0;
            r_rspError  <= 1'b0;
            r_num2      <= '0;
            r_outSel    <= 7'd0;
            r_firstResp <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= bus.cmd_op;
                        r_data <= bus.cmd_data;
                        r_num2 <= bus.cmd_data;
                        if (bus.cmd_op != c_OP_LOAD) r_outSel <= w_opSel;
                    end
                end
                S_ISSUE: begin
                    r_count <= 4'd0;
                    if (r_op == c_OP_LOAD) begin
                        r_rspData   <= r_data;
                        r_rspError  <= 1'b0;
                        r_rspValid  <= 1'b1;
                        r_firstResp <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_count <= r_count + 4'd1;
                    if (r_count == c_LAT_LAST) begin
                        r_rspData   <= alu_result;
                        r_rspError  <= alu_overflow && w_isArith;
                        r_rspValid  <= 1'b1;
                        r_firstResp <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_firstResp <= 1'b0;
                    if (bus.rsp_ready) r_rspValid <= 1'b0;
                end
                S_ERROR: begin
                    // Error flag stays visible for the whole ERROR stay.
                    if (bus.err_clear) r_rspError <= 1'b0;
                end
                default: begin
                    r_rspValid  <= 1'b0;
                    r_rspError  <= 1'b0;
                    r_firstResp <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_data  = r_rspData;
    assign bus.rsp_error = r_rspError;
    assign alu_num2      = r_num2;
    assign alu_in_sel    = w_inSel;
    assign alu_out_sel   = r_outSel;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. The ALU is
//                modelled by driving alu_result/alu_overflow directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] alu_num2;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic [2:0] state;

    int testCount = 0;
    int failCount = 0;

    alu_sequencer_if #(.WIDTH(8)) bus ();

    alu_sequencer #(.WIDTH(8), .ALU_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_num2     (alu_num2),
        .alu_in_sel   (alu_in_sel),
        .alu_out_sel  (alu_out_sel),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command with rsp_ready held high and watch a fixed window.
    // Cycle 1 is the first cycle after the accepting edge.
    task automatic runOp(input logic [2:0] op, input logic [7:0] data,
                         input logic [7:0] res, input logic ovf,
                         output int validCyc, output int wbCnt, output int ldCnt,
                         output logic [7:0] rdata, output logic rerr);
        validCyc = 0; wbCnt = 0; ldCnt = 0; rdata = 8'h00; rerr = 1'b0;
        alu_result    = res;
        alu_overflow  = ovf;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'hA5;
        for (int c = 1; c <= 8; c++) begin
            if (alu_in_sel == 3'b001) wbCnt++;
            if (alu_in_sel == 3'b010) ldCnt++;
            if (bus.rsp_valid && validCyc == 0) begin
                validCyc = c;
                rdata    = bus.rsp_data;
                rerr     = bus.rsp_error;
            end
            tick();
        end
    endtask

    initial begin
        int         vc, wb, ld, stableErr;
        logic [7:0] rd;
        logic       re;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_data = 8'h00;
        bus.rsp_ready = 1'b0; bus.err_clear = 1'b0;
        alu_result = 8'h00; alu_overflow = 1'b0;
        tick(); tick();

        // Reset state
        checkValue("rst_state",   32'(state), 32'd0);
        checkValue("rst_rspValid", 32'(bus.rsp_valid), 32'd0);
        checkValue("rst_rspData", 32'(bus.rsp_data), 32'h00);
        checkValue("rst_rspError", 32'(bus.rsp_error), 32'd0);
        checkValue("rst_num2",    32'(alu_num2), 32'h00);
        checkValue("rst_inSel",   32'(alu_in_sel), 32'd0);
        checkValue("rst_outSel",  32'(alu_out_sel), 32'd0);
        rst = 1'b0;
        tick();
        checkValue("idle_cmdReady", 32'(bus.cmd_ready), 32'd1);

        // err_clear outside ERROR has no effect
        bus.err_clear = 1'b1;
        #1;
        checkValue("errclr_idle_inSel", 32'(alu_in_sel), 32'd0);
        tick();
        bus.err_clear = 1'b0;
        checkValue("errclr_idle_state", 32'(state), 32'd0);

        // LOAD 05
        runOp(3'd7, 8'h05, 8'h00, 1'b0, vc, wb, ld, rd, re);
        checkValue("load_latency", 32'(vc), 32'd2);
        checkValue("load_data",   32'(rd), 32'h05);
        checkValue("load_error",  32'(re), 32'd0);
        checkValue("load_ldPulse", 32'(ld), 32'd1);
        checkValue("load_wbPulse", 32'(wb), 32'd0);
        checkValue("load_outSel", 32'(alu_out_sel), 32'd0);
        checkValue("load_num2",   32'(alu_num2), 32'h05);
        checkValue("load_state",  32'(state), 32'd0);

        // ADD 03, ALU returns 08
        runOp(3'd4, 8'h03, 8'h08, 1'b0, vc, wb, ld, rd, re);
        checkValue("add_outSel",  32'(alu_out_sel), 32'b0010000);
        checkValue("add_num2",    32'(alu_num2), 32'h03);
        checkValue("add_latency", 32'(vc), 32'd4);
        checkValue("add_data",    32'(rd), 32'h08);
        checkValue("add_error",   32'(re), 32'd0);
        checkValue("add_wbPulse", 32'(wb), 32'd1);
        checkValue("add_state",   32'(state), 32'd0);

        // NOT with overflow forced: flag ignored, writeback happens
        runOp(3'd2, 8'h00, 8'h5A, 1'b1, vc, wb, ld, rd, re);
        checkValue("not_data",    32'(rd), 32'h5A);
        checkValue("not_error",   32'(re), 32'd0);
        checkValue("not_wbPulse", 32'(wb), 32'd1);

        // OR selects the or unit
        runOp(3'd1, 8'h0F, 8'h3F, 1'b0, vc, wb, ld, rd, re);
        checkValue("or_outSel",   32'(alu_out_sel), 32'b0000010);
        checkValue("or_data",     32'(rd), 32'h3F);

        // MULT with overflow -> ERROR, no writeback
        runOp(3'd6, 8'h40, 8'h10, 1'b1, vc, wb, ld, rd, re);
        checkValue("mult_outSel", 32'(alu_out_sel), 32'b1000000);
        checkValue("mult_latency", 32'(vc), 32'd4);
        checkValue("mult_error",  32'(re), 32'd1);
        checkValue("mult_wbPulse", 32'(wb), 32'd0);
        checkValue("err_state",   32'(state), 32'd4);
        checkValue("err_cmdReady", 32'(bus.cmd_ready), 32'd0);
        checkValue("err_rspError", 32'(bus.rsp_error), 32'd1);
        bus.rsp_ready = 1'b0;
        bus.err_clear = 1'b1;
        #1;
        checkValue("errclr_inSel", 32'(alu_in_sel), 32'b100);
        tick();
        bus.err_clear = 1'b0;
        #1;
        checkValue("errclr_state",   32'(state), 32'd0);
        checkValue("errclr_cmdReady", 32'(bus.cmd_ready), 32'd1);
        checkValue("errclr_rspError", 32'(bus.rsp_error), 32'd0);
        checkValue("errclr_inSelAfter", 32'(alu_in_sel), 32'd0);

        // Back-pressure: SUB, rsp_ready low, cmd_valid kept high
        alu_result = 8'h07; alu_overflow = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_data = 8'h01;
        tick();
        bus.cmd_op = 3'd7; bus.cmd_data = 8'hEE;
        wb = 0; stableErr = 0;
        for (int c = 0; c < 8 && !bus.rsp_valid; c++) begin
            if (alu_in_sel == 3'b001) wb++;
            tick();
        end
        checkValue("bp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (alu_in_sel == 3'b001) wb++;
            if (bus.rsp_data !== 8'h07 || bus.cmd_ready !== 1'b0 ||
                bus.rsp_valid !== 1'b1) stableErr++;
            tick();
        end
        checkValue("bp_stable",  32'(stableErr), 32'd0);
        checkValue("bp_wbPulse", 32'(wb), 32'd1);
        checkValue("bp_state",   32'(state), 32'd3);
        bus.rsp_ready = 1'b1;
        tick();
        checkValue("bp_idle",     32'(state), 32'd0);
        checkValue("bp_cmdReady", 32'(bus.cmd_ready), 32'd1);
        tick();
        checkValue("bp_nextAccept", 32'(state), 32'd1);
        bus.cmd_valid = 1'b0;
        tick();
        checkValue("bp_nextData", 32'(bus.rsp_data), 32'hEE);
        tick();

        // Reset mid-WAIT after ADD accepted
        alu_result = 8'h99; alu_overflow = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_data = 8'h02;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checkValue("midrst_inWait", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        checkValue("midrst_state",   32'(state), 32'd0);
        checkValue("midrst_rspValid", 32'(bus.rsp_valid), 32'd0);
        checkValue("midrst_inSel",   32'(alu_in_sel), 32'd0);
        tick();
        rst = 1'b0;
        wb = 0;
        for (int c = 0; c < 6; c++) begin
            if (alu_in_sel != 3'b000) wb++;
            tick();
        end
        checkValue("midrst_noWb",  32'(wb), 32'd0);
        checkValue("midrst_idle",  32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
